// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: boot sequencing, branch/jump redirect, stall hold,
// exception/eret vectoring and fetch address error detection.
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_Stall,
  input  logic [2:0]  D_nPCSel,
  input  logic        D_Zero,
  input  logic [15:0] D_Imm16,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_PC,
  input  logic        Req,
  input  logic        M_eret,
  input  logic [31:0] EPC,
  output logic [31:0] F_PC,
  output logic        F_Valid,
  output logic        F_BD,
  output logic        F_ExcAdEL
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  localparam logic [2:0] SEL_BEQ = 3'b001;
  localparam logic [2:0] SEL_JAL = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b011;
  localparam logic [2:0] SEL_BNE = 3'b100;

  state_t      state, next_state;
  logic [31:0] next_pc, next_target;
  logic [31:0] branch_target, jal_target, seq_pc;
  logic        next_bd, taken, is_cti;

  assign branch_target = D_PC + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
  assign jal_target    = {D_PC[31:28], D_Imm26, 2'b00};
  assign seq_pc        = F_PC + 32'd4;

  // Untaken BEQ/BNE still mark the following fetch as a delay slot.
  assign is_cti = (D_nPCSel == SEL_BEQ) || (D_nPCSel == SEL_JAL) ||
                  (D_nPCSel == SEL_JR)  || (D_nPCSel == SEL_BNE);

  always_comb begin
    taken       = 1'b0;
    next_target = seq_pc;
    case (D_nPCSel)
      SEL_BEQ: begin taken = D_Zero;  next_target = branch_target; end
      SEL_BNE: begin taken = ~D_Zero; next_target = branch_target; end
      SEL_JAL: begin taken = 1'b1;    next_target = jal_target;    end
      SEL_JR:  begin taken = 1'b1;    next_target = D_RD1;         end
      default: ;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    next_pc    = F_PC;
    next_bd    = F_BD;
    case (state)
      BOOT: next_state = RUN;
      default: begin
        if (Req) begin
          next_state = FLUSH;
          next_pc    = HANDLER_PC;
          next_bd    = 1'b0;
        end else if (M_eret) begin
          next_state = FLUSH;
          next_pc    = EPC;
          next_bd    = 1'b0;
        end else if (D_Stall) begin
          next_state = RUN;
        end else begin
          next_state = RUN;
          next_pc    = taken ? next_target : seq_pc;
          next_bd    = is_cti;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      F_PC  <= RESET_PC;
      F_BD  <= 1'b0;
    end else begin
      state <= next_state;
      F_PC  <= next_pc;
      F_BD  <= next_bd;
    end
  end

  assign F_Valid   = (state != BOOT);
  assign F_ExcAdEL = F_Valid & ((F_PC[1:0] != 2'b00) | (F_PC < TEXT_LO) | (F_PC > TEXT_HI));

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: directed vector table, hand-written
// stall/exception/reset sequences, and randomized traffic against a reference model.
module tb_f_pc_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

  logic        clk, reset, D_Stall, D_Zero, Req, M_eret;
  logic [2:0]  D_nPCSel;
  logic [15:0] D_Imm16;
  logic [25:0] D_Imm26;
  logic [31:0] D_RD1, D_PC, EPC, F_PC;
  logic        F_Valid, F_BD, F_ExcAdEL;

  f_pc_ctrl #(
    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .TEXT_LO(TEXT_LO), .TEXT_HI(TEXT_HI)
  ) dut (
    .clk(clk), .reset(reset), .D_Stall(D_Stall), .D_nPCSel(D_nPCSel), .D_Zero(D_Zero),
    .D_Imm16(D_Imm16), .D_Imm26(D_Imm26), .D_RD1(D_RD1), .D_PC(D_PC), .Req(Req),
    .M_eret(M_eret), .EPC(EPC), .F_PC(F_PC), .F_Valid(F_Valid), .F_BD(F_BD),
    .F_ExcAdEL(F_ExcAdEL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: just "still booting", current PC and delay-slot flag.
  logic [31:0] m_pc;
  logic        m_bd, m_boot;

  typedef struct {
    logic [2:0]  sel;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rd1;
    logic [31:0] dpc;
    logic [31:0] exp_pc;
    logic        exp_bd;
    logic        exp_exc;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    D_Stall = 0; D_nPCSel = 3'b000; D_Zero = 0; D_Imm16 = '0; D_Imm26 = '0;
    D_RD1 = '0; D_PC = '0; Req = 0; M_eret = 0; EPC = '0;
  endtask

  function automatic logic exp_exc(input logic [31:0] pc, input logic valid);
    return valid && ((pc % 4) != 0 || pc < TEXT_LO || pc > TEXT_HI);
  endfunction

  task automatic model_step();
    logic        tk;
    logic [31:0] tgt;
    if (m_boot) begin
      m_boot = 0;
    end else if (Req) begin
      m_pc = HANDLER_PC; m_bd = 0;
    end else if (M_eret) begin
      m_pc = EPC; m_bd = 0;
    end else if (!D_Stall) begin
      tk  = 0;
      tgt = m_pc + 4;
      case (D_nPCSel)
        3'd1: begin tk = D_Zero;  tgt = D_PC + 4 + 32'($signed(D_Imm16)) * 4; end
        3'd4: begin tk = !D_Zero; tgt = D_PC + 4 + 32'($signed(D_Imm16)) * 4; end
        3'd2: begin tk = 1; tgt = (D_PC & 32'hF000_0000) + 32'(D_Imm26) * 4; end
        3'd3: begin tk = 1; tgt = D_RD1; end
        default: ;
      endcase
      m_pc = tk ? tgt : m_pc + 4;
      m_bd = (D_nPCSel >= 3'd1 && D_nPCSel <= 3'd4);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},  F_PC,      m_pc);
    check({tag, ".vld"}, F_Valid,   !m_boot);
    check({tag, ".bd"},  F_BD,      m_bd);
    check({tag, ".exc"}, F_ExcAdEL, exp_exc(m_pc, !m_boot));
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a falling edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1;
    m_boot = 1; m_pc = RESET_PC; m_bd = 0;
    #1;
    check({tag, ".rst_pc"},  F_PC,      RESET_PC);
    check({tag, ".rst_vld"}, F_Valid,   0);
    check({tag, ".rst_bd"},  F_BD,      0);
    check({tag, ".rst_exc"}, F_ExcAdEL, 0);
    @(negedge clk);
    reset = 0;
    set_idle();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic bd, input logic exc);
    check({tag, ".pc"},  F_PC,      pc);
    check({tag, ".vld"}, F_Valid,   1);
    check({tag, ".bd"},  F_BD,      bd);
    check({tag, ".exc"}, F_ExcAdEL, exc);
  endtask

  initial begin
    //            sel    z     imm16     imm26         rd1           dpc           exp_pc        bd exc
    vec[0]  = '{3'd0, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0,        32'h0000_3004, 0, 0};
    vec[1]  = '{3'd0, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0,        32'h0000_3008, 0, 0};
    vec[2]  = '{3'd1, 1'b1, 16'hFFFE, 26'h0,       32'h0,        32'h0000_3010, 32'h0000_300C, 1, 0};
    vec[3]  = '{3'd1, 1'b0, 16'hFFFE, 26'h0,       32'h0,        32'h0000_3010, 32'h0000_3010, 1, 0};
    vec[4]  = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'h0000_3001, 32'h0,       32'h0000_3001, 1, 1};
    vec[5]  = '{3'd2, 1'b0, 16'h0000, 26'h0000C40, 32'h0,        32'h0000_3000, 32'h0000_3100, 1, 0};
    vec[6]  = '{3'd4, 1'b0, 16'h0004, 26'h0,       32'h0,        32'h0000_3100, 32'h0000_3114, 1, 0};
    vec[7]  = '{3'd4, 1'b1, 16'h0004, 26'h0,       32'h0,        32'h0000_3114, 32'h0000_3118, 1, 0};
    vec[8]  = '{3'd5, 1'b1, 16'h0040, 26'h0000C40, 32'h0000_5000, 32'h0000_3000, 32'h0000_311C, 0, 0};
    vec[9]  = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'h0000_7000, 32'h0,       32'h0000_7000, 1, 1};
    vec[10] = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'h0000_6FFC, 32'h0,       32'h0000_6FFC, 1, 0};
    vec[11] = '{3'd0, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0,        32'h0000_7000, 0, 1};
    vec[12] = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'h0000_2FFC, 32'h0,       32'h0000_2FFC, 1, 1};
    vec[13] = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1, 1};
    vec[14] = '{3'd7, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0,        32'h0000_0000, 0, 1};
    vec[15] = '{3'd3, 1'b0, 16'h0000, 26'h0,       32'h0000_3000, 32'h0,       32'h0000_3000, 1, 0};

    set_idle();
    reset = 1;
    m_boot = 1; m_pc = RESET_PC; m_bd = 0;
    #2;
    check("por.pc",  F_PC,      RESET_PC);
    check("por.vld", F_Valid,   0);
    check("por.bd",  F_BD,      0);
    check("por.exc", F_ExcAdEL, 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("boot.vld", F_Valid, 0);
    check("boot.pc",  F_PC,    32'h0000_3000);
    tick();
    expect_out("run0", 32'h0000_3000, 0, 0);

    for (int i = 0; i < 16; i++) begin
      D_nPCSel = vec[i].sel; D_Zero = vec[i].zero; D_Imm16 = vec[i].imm16;
      D_Imm26 = vec[i].imm26; D_RD1 = vec[i].rd1; D_PC = vec[i].dpc;
      tick();
      expect_out($sformatf("vec%0d", i), vec[i].exp_pc, vec[i].exp_bd, vec[i].exp_exc);
    end

    // Stalled JAL: PC and delay-slot flag frozen, then redirect once released.
    set_idle();
    tick();
    expect_out("pre_stall", 32'h0000_3004, 0, 0);
    D_Stall = 1; D_nPCSel = 3'd2; D_PC = 32'h0000_3000; D_Imm26 = 26'h0000C40;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 32'h0000_3004, 0, 0);
    end
    D_Stall = 0;
    tick();
    expect_out("stall_rel", 32'h0000_3100, 1, 0);

    // Req beats M_eret and stall; FLUSH lasts one cycle; eret later returns to EPC.
    D_Stall = 1; Req = 1; M_eret = 1; EPC = 32'h0000_3040;
    tick();
    expect_out("req_all", 32'h0000_4180, 0, 0);
    set_idle();
    tick();
    expect_out("flush_end", 32'h0000_4184, 0, 0);
    M_eret = 1; EPC = 32'h0000_3040;
    tick();
    expect_out("eret", 32'h0000_3040, 0, 0);
    set_idle();
    Req = 1;
    tick();
    expect_out("req_in_flush", 32'h0000_4180, 0, 0);

    // Reset during FLUSH and during a stalled jump abandons the pending target.
    set_idle();
    m_pc = 32'h0000_4180; m_bd = 0; m_boot = 0;
    pulse_reset("rst_flush");
    tick();
    expect_out("rst_boot", 32'h0000_3000, 0, 0);
    D_Stall = 1; D_nPCSel = 3'd2; D_PC = 32'h0000_3000; D_Imm26 = 26'h0000C44;
    tick();
    expect_out("rst_stall_pre", 32'h0000_3000, 0, 0);
    pulse_reset("rst_stall");
    tick();
    expect_out("rst_stall_boot", 32'h0000_3000, 0, 0);
    tick();
    expect_out("rst_stall_seq", 32'h0000_3004, 0, 0);

    // Randomized traffic against the model.
    pulse_reset("rnd_start");
    for (int i = 0; i < 600; i++) begin
      if (m_boot) begin
        set_idle();
      end else begin
        D_Stall  = ($urandom_range(0, 3) == 0);
        D_nPCSel = 3'($urandom_range(0, 7));
        D_Zero   = 1'($urandom_range(0, 1));
        D_Imm16  = 16'($urandom);
        D_Imm26  = 26'($urandom);
        D_PC     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_3000 + 32'($urandom_range(0, 16'h0FFF)) * 4;
        D_RD1    = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0000_3000 + 32'($urandom_range(0, 16'h0FFF)) * 4;
        Req      = ($urandom_range(0, 15) == 0);
        M_eret   = ($urandom_range(0, 15) == 0);
        EPC      = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0000_3000 + 32'($urandom_range(0, 16'h0FFF)) * 4;
      end
      tick();
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 63) == 0) pulse_reset($sformatf("rnd_rst%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
